// File: rtl/heap_ram_arbiter.sv
// Round-robin arbiter sharing the single-ported heap RAM between CPU and DMA; 3 cycles per access.
// Requesters hold valid until their one-cycle ready pulse; optional HEAP_ARB_ERR_EN flags out-of-range addresses.
module heap_ram_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic [31:0]           cpu_rdata,
  input  logic                  dma_valid,
  output logic                  dma_ready,
  input  logic [31:0]           dma_addr,
  input  logic [31:0]           dma_wdata,
  input  logic [3:0]            dma_wstrb,
  output logic [31:0]           dma_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Per-access attributes needed after the RAM strobe has gone out.
  typedef struct packed {
    logic is_dma;
    logic is_wr;
    logic oor;
  } gnt_t;

  state_t state_q, state_d;
  gnt_t   gnt_q;
  logic   last_dma_q;
  logic   grant, pick_dma, sel_oor;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        unused_addr_bits;

  always_comb begin
    pick_dma  = dma_valid && (!cpu_valid || !last_dma_q);
    grant     = (state_q == IDLE) && (cpu_valid || dma_valid);
    sel_addr  = pick_dma ? dma_addr  : cpu_addr;
    sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
    sel_wstrb = pick_dma ? dma_wstrb : cpu_wstrb;
  end

`ifdef HEAP_ARB_ERR_EN
  logic err_q;
  assign sel_oor          = |sel_addr[31:ADDR_WIDTH];
  assign unused_addr_bits = ^sel_addr[1:0];
  assign err              = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (grant && sel_oor) begin
      err_q <= 1'b1;
    end
  end
`else
  // Upper address bits simply wrap into the heap window.
  assign sel_oor          = 1'b0;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_WIDTH], sel_addr[1:0]};
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM strobe is registered on the grant edge so it is live throughout ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dma_q <= 1'b1;
      gnt_q      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 4'b0000;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 4'b0000;
      if (grant) begin
        last_dma_q   <= pick_dma;
        gnt_q.is_dma <= pick_dma;
        gnt_q.is_wr  <= |sel_wstrb;
        gnt_q.oor    <= sel_oor;
        ram_en       <= !sel_oor;
        ram_we       <= sel_oor ? 4'b0000 : sel_wstrb;
        ram_addr     <= sel_addr[ADDR_WIDTH-1:2];
        ram_wdata    <= sel_wdata;
      end
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    cpu_rdata = 32'h0;
    dma_rdata = 32'h0;
    if (state_q == RESP) begin
      if (gnt_q.is_dma) begin
        dma_ready = 1'b1;
        dma_rdata = (gnt_q.is_wr || gnt_q.oor) ? 32'h0 : ram_rdata;
      end else begin
        cpu_ready = 1'b1;
        cpu_rdata = (gnt_q.is_wr || gnt_q.oor) ? 32'h0 : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_heap_ram_arbiter.sv
// Directed bench for heap_ram_arbiter with a behavioural single-port RAM behind it.
module tb_heap_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_valid, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        dma_valid, dma_ready;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_wstrb;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        err;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  logic [31:0] mem [0:4095];

  heap_ram_arbiter #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write synchronous RAM with byte enables.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " cpu_ready"}, cpu_ready, 0);
    check({tag, " dma_ready"}, dma_ready, 0);
    check({tag, " ram_en"},    ram_en,    0);
    check({tag, " ram_we"},    ram_we,    0);
    check({tag, " ram_addr"},  ram_addr,  0);
    check({tag, " ram_wdata"}, ram_wdata, 0);
    check({tag, " cpu_rdata"}, cpu_rdata, 0);
    check({tag, " dma_rdata"}, dma_rdata, 0);
    check({tag, " err"},       err,       0);
  endtask

  // One complete access from IDLE; fields are scrambled after the grant to prove they were latched.
  task automatic do_access(input string tag, input bit is_dma, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp_rd, input logic [11:0] exp_ra, input bit exp_en);
    if (is_dma) begin
      dma_valid = 1'b1; dma_addr = addr; dma_wdata = wdata; dma_wstrb = wstrb;
    end else begin
      cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    end
    tick();
    check({tag, " issue ram_en"}, ram_en, exp_en);
    check({tag, " issue ram_we"}, ram_we, exp_en ? wstrb : 4'b0000);
    if (exp_en) check({tag, " issue ram_addr"}, ram_addr, exp_ra);
    if (wstrb != 4'b0000 && exp_en) check({tag, " issue ram_wdata"}, ram_wdata, wdata);
    check({tag, " issue no ready"}, cpu_ready | dma_ready, 0);
    if (is_dma) begin
      dma_addr = 32'h0000_0AA8; dma_wdata = 32'hBAD0_BAD0; dma_wstrb = ~wstrb;
    end else begin
      cpu_addr = 32'h0000_0AA8; cpu_wdata = 32'hBAD0_BAD0; cpu_wstrb = ~wstrb;
    end
    tick();
    check({tag, " resp own ready"},   is_dma ? dma_ready : cpu_ready, 1);
    check({tag, " resp other ready"}, is_dma ? cpu_ready : dma_ready, 0);
    check({tag, " resp own rdata"},   is_dma ? dma_rdata : cpu_rdata, exp_rd);
    check({tag, " resp other rdata"}, is_dma ? cpu_rdata : dma_rdata, 0);
    cpu_valid = 1'b0; dma_valid = 1'b0;
    tick();
    check({tag, " idle ram_en"}, ram_en, 0);
    check({tag, " idle ready"},  cpu_ready | dma_ready, 0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    dma_valid = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_wstrb = 4'h0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Seed words, then the basic CPU read with its cycle timing.
    do_access("dma wr w4",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 12'h004, 1'b1);
    do_access("dma wr w0",   1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 12'h000, 1'b1);
    do_access("cpu rd w4",   1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 12'h004, 1'b1);

    // Partial-word DMA write at the top of the window.
    do_access("cpu wr top",  1'b0, 32'h0000_3FFC, 32'hAAAA_BBBB, 4'hF, 32'h0, 12'hFFF, 1'b1);
    do_access("dma wr half", 1'b1, 32'h0000_3FFC, 32'h1234_5678, 4'b0011, 32'h0, 12'hFFF, 1'b1);
    do_access("cpu rd top",  1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 32'hAAAA_5678, 12'hFFF, 1'b1);

    // Continuous dual requests after reset: CPU wins the first tie, then strict alternation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0010; cpu_wstrb = 4'h0;
    dma_valid = 1'b1; dma_addr = 32'h0000_3FFC; dma_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr issue addr", ram_addr, (i % 2 == 0) ? 12'h004 : 12'hFFF);
      check("rr issue no ready", cpu_ready | dma_ready, 0);
      tick();
      check("rr cpu_ready", cpu_ready, (i % 2 == 0) ? 1 : 0);
      check("rr dma_ready", dma_ready, (i % 2 == 0) ? 0 : 1);
      check("rr rdata", (i % 2 == 0) ? cpu_rdata : dma_rdata,
            (i % 2 == 0) ? 32'hDEAD_BEEF : 32'hAAAA_5678);
      if (i == 7) begin
        cpu_valid = 1'b0; dma_valid = 1'b0;
      end
      tick();
      check("rr idle no ready", cpu_ready | dma_ready, 0);
    end
    tick();
    check("rr quiescent ram_en", ram_en, 0);

    // Reset during ISSUE of a CPU write aborts it without a ready pulse.
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h5555_5555; cpu_wstrb = 4'hF;
    tick();
    check("abort issue ram_en", ram_en, 1);
    reset = 1'b1; cpu_valid = 1'b0;
    tick();
    check_idle_outputs("abort");
    reset = 1'b0;
    tick();
    check("abort no late ready", cpu_ready, 0);
    tick();
    check("abort still no ready", cpu_ready, 0);
    do_access("cpu rd after abort", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 12'h004, 1'b1);

    // Address beyond the 16 KiB window.
`ifdef HEAP_ARB_ERR_EN
    do_access("cpu rd oor", 1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 12'h000, 1'b0);
    check("oor err set", err, 1);
    do_access("cpu rd after oor", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 12'h004, 1'b1);
    check("oor err sticky", err, 1);
`else
    do_access("cpu rd wrap", 1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 12'h000, 1'b1);
    check("wrap err clear", err, 0);
`endif
    reset = 1'b1;
    tick();
    check("final reset err", err, 0);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
